forwarding_hazard_unit: RTL and testbench
=========================================

Name: forwarding_hazard_unit

Overview:
- Control end of the EX-stage operand forwarding interface for the 16-bit pipeline.
- Generates the 2-bit forwardA/forwardB select codes that drive the EX forwarding muxes: 00 = register-file operand, 10 = EX/MEM ALU result, 01 = MEM/WB writeback result.
- Keeps a shadow pipeline of destination-register info for the EX and MEM stages.
- Detects load-use hazards and asserts a one-cycle stall with bubble insertion.
- Counts stall cycles for performance monitoring.

Parameters:
- REG_ADDR_W, 4, register address width (16 architectural registers; register 0 is hardwired zero).
- CNT_W, 16, width of the saturating stall counter.

Ports:
- clock  input  1  system clock, rising-edge active
- reset  input  1  synchronous, active-high reset
- id_valid  input  1  ID stage holds a real instruction
- id_rs1  input  REG_ADDR_W  source register 1 of the ID instruction
- id_rs2  input  REG_ADDR_W  source register 2 of the ID instruction
- id_use_rs1  input  1  ID instruction reads rs1
- id_use_rs2  input  1  ID instruction reads rs2
- id_rd  input  REG_ADDR_W  destination register of the ID instruction
- id_regWrite  input  1  ID instruction writes id_rd
- id_memRead  input  1  ID instruction is a load
- flush  input  1  branch taken: ID instruction is squashed
- forwardA  output  2  select for EX operand A (registered)
- forwardB  output  2  select for EX operand B (registered)
- stall  output  1  freeze PC and IF/ID this cycle (combinational)
- stall_count  output  CNT_W  number of stall cycles since reset, saturating

Behaviour:
- One clock named clock; reset is synchronous and active-high, sampled on the rising edge of clock.
- Shadow state, updated every rising edge:
  - EX stage: ex_valid, ex_rd, ex_regWrite, ex_memRead.
  - MEM stage: mem_valid, mem_rd, mem_regWrite.
- Reset: ex_valid=0, mem_valid=0, all shadow fields 0, forwardA=00, forwardB=00, stall_count=0. Reset has priority over all other inputs.
- Hazard (combinational), true when all of the following hold:
  - id_valid, ex_valid, ex_memRead, ex_regWrite, and ex_rd!=0
  - and either (id_use_rs1 and id_rs1==ex_rd) or (id_use_rs2 and id_rs2==ex_rd)
- stall = hazard AND NOT flush. Flush overrides stall.
- Per-edge update, in priority order:
  - reset: as above.
  - flush=1: EX <- bubble (valid=0); MEM <- EX; forwardA and forwardB <- 00; stall_count unchanged.
  - stall=1: EX <- bubble; MEM <- EX; forwardA and forwardB <- 00; stall_count <- stall_count+1, saturating at all-ones.
  - otherwise: EX <- {id_valid, id_rd, id_regWrite, id_memRead}; MEM <- EX; forwardA <- sel(id_rs1, id_use_rs1); forwardB <- sel(id_rs2, id_use_rs2).
- sel(rs, use), evaluated against the shadow state before the edge:
  - 00 if id_valid=0, use=0, or rs=0
  - else 10 if ex_valid, ex_regWrite, and ex_rd==rs (the newest producer wins)
  - else 01 if mem_valid, mem_regWrite, and mem_rd==rs
  - else 00
  - Code 11 is never produced.
- Latency: a select is registered on the edge where the instruction enters EX, and is valid for that instruction's entire EX cycle.
- Load-use sequence:
  - The stall lasts exactly 1 cycle, because the inserted bubble clears the EX load match.
  - On the next edge the load sits in MEM/WB, so the consumer receives 01.
  - Back-to-back stalls on the same load are impossible.
- The register file is write-through, so a producer in the WB stage needs no forwarding code.
- A destination of 0 never causes forwarding or a stall.
- Instructions with id_valid=0 enter EX as bubbles.
- Reset asserted mid-stall: stall deasserts after the reset edge, because the shadow stages are now empty.

Test Plan:
- Reset then idle -> forwardA=forwardB=00, stall=0, stall_count=0.
- ADD r3 (regWrite) followed immediately by SUB reading rs1=r3, rs2=r5 -> when SUB enters EX: forwardA=10, forwardB=00.
- ADD r4, then an unrelated instruction, then an instruction reading r4 in both operands -> forwardA=forwardB=01.
- r2 written by the instructions in both EX and MEM, next instruction reads r2 -> 10 (priority to the newest producer).
- LOAD r6, then ADD reading r6 -> stall=1 for one cycle, stall_count=1, bubble issued with 00/00, then ADD in EX with forward=01.
- Load-use hazard with flush=1 in the same cycle -> stall=0, forwards=00, stall_count unchanged.
- Consumer reads r0 while a producer writes r0 -> 00 and no stall.
- stall_count preloaded near all-ones via repeated hazards -> saturates at 0xFFFF and holds.

Source files
------------

// File: rtl/forwarding_hazard_unit.sv
// EX operand forwarding selects and load-use stall control
// for the 16-bit pipeline, with a saturating stall counter.
module forwarding_hazard_unit #(
  parameter int REG_ADDR_W = 4,
  parameter int CNT_W      = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_use_rs1,
  input  logic                  id_use_rs2,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  id_regWrite,
  input  logic                  id_memRead,
  input  logic                  flush,
  output logic [1:0]            forwardA,
  output logic [1:0]            forwardB,
  output logic                  stall,
  output logic [CNT_W-1:0]      stall_count
);

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_EX  = 2'b10;
  localparam logic [1:0] FWD_MEM = 2'b01;

  logic                  ex_valid_q, ex_valid_d;
  logic [REG_ADDR_W-1:0] ex_rd_q, ex_rd_d;
  logic                  ex_rw_q, ex_rw_d;
  logic                  ex_mr_q, ex_mr_d;
  logic                  mem_valid_q, mem_valid_d;
  logic [REG_ADDR_W-1:0] mem_rd_q, mem_rd_d;
  logic                  mem_rw_q, mem_rw_d;
  logic [1:0]            fwd_a_q, fwd_a_d;
  logic [1:0]            fwd_b_q, fwd_b_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;

  logic hazard;
  logic ex_load;
  logic rs1_hit;
  logic rs2_hit;

  // Newest producer (EX) wins over the older one (MEM).
  function automatic logic [1:0] sel(
    input logic [REG_ADDR_W-1:0] rs,
    input logic                  use_rs
  );
    logic [1:0] r;
    r = FWD_RF;
    if (id_valid && use_rs && rs != '0) begin
      if (ex_valid_q && ex_rw_q && ex_rd_q == rs)
        r = FWD_EX;
      else if (mem_valid_q && mem_rw_q && mem_rd_q == rs)
        r = FWD_MEM;
    end
    return r;
  endfunction

  assign ex_load = ex_valid_q && ex_mr_q
                && ex_rw_q && ex_rd_q != '0;
  assign rs1_hit = id_use_rs1 && id_rs1 == ex_rd_q;
  assign rs2_hit = id_use_rs2 && id_rs2 == ex_rd_q;
  assign hazard  = id_valid && ex_load
                && (rs1_hit || rs2_hit);
  assign stall   = hazard && !flush;

  always_comb begin
    mem_valid_d = ex_valid_q;
    mem_rd_d    = ex_rd_q;
    mem_rw_d    = ex_rw_q;
    ex_valid_d  = 1'b0;
    ex_rd_d     = '0;
    ex_rw_d     = 1'b0;
    ex_mr_d     = 1'b0;
    fwd_a_d     = FWD_RF;
    fwd_b_d     = FWD_RF;
    cnt_d       = cnt_q;
    unique case (1'b1)
      flush: begin
      end
      stall: begin
        if (cnt_q != '1)
          cnt_d = cnt_q + 1'b1;
      end
      default: begin
        ex_valid_d = id_valid;
        ex_rd_d    = id_rd;
        ex_rw_d    = id_regWrite;
        ex_mr_d    = id_memRead;
        fwd_a_d    = sel(id_rs1, id_use_rs1);
        fwd_b_d    = sel(id_rs2, id_use_rs2);
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      ex_valid_q  <= 1'b0;
      ex_rd_q     <= '0;
      ex_rw_q     <= 1'b0;
      ex_mr_q     <= 1'b0;
      mem_valid_q <= 1'b0;
      mem_rd_q    <= '0;
      mem_rw_q    <= 1'b0;
      fwd_a_q     <= FWD_RF;
      fwd_b_q     <= FWD_RF;
      cnt_q       <= '0;
    end else begin
      ex_valid_q  <= ex_valid_d;
      ex_rd_q     <= ex_rd_d;
      ex_rw_q     <= ex_rw_d;
      ex_mr_q     <= ex_mr_d;
      mem_valid_q <= mem_valid_d;
      mem_rd_q    <= mem_rd_d;
      mem_rw_q    <= mem_rw_d;
      fwd_a_q     <= fwd_a_d;
      fwd_b_q     <= fwd_b_d;
      cnt_q       <= cnt_d;
    end
  end

  assign forwardA    = fwd_a_q;
  assign forwardB    = fwd_b_q;
  assign stall_count = cnt_q;

endmodule

// File: tb/tb_forwarding_hazard_unit.sv
// Directed-vector scoreboard bench for forwarding_hazard_unit;
// a narrow-counter twin checks stall counter saturation.
module tb_forwarding_hazard_unit;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       id_valid = 1'b0;
  logic [3:0] id_rs1 = '0;
  logic [3:0] id_rs2 = '0;
  logic       id_use_rs1 = 1'b0;
  logic       id_use_rs2 = 1'b0;
  logic [3:0] id_rd = '0;
  logic       id_regWrite = 1'b0;
  logic       id_memRead = 1'b0;
  logic       flush = 1'b0;

  logic [1:0]  fa, fb, fa_s, fb_s;
  logic        st, st_s;
  logic [15:0] cnt;
  logic [3:0]  cnt_s;

  always #5 clock = ~clock;

  forwarding_hazard_unit dut (
    .clock(clock), .reset(reset),
    .id_valid(id_valid),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1),
    .id_use_rs2(id_use_rs2),
    .id_rd(id_rd),
    .id_regWrite(id_regWrite),
    .id_memRead(id_memRead),
    .flush(flush),
    .forwardA(fa), .forwardB(fb),
    .stall(st), .stall_count(cnt)
  );

  forwarding_hazard_unit #(.CNT_W(4)) dut_s (
    .clock(clock), .reset(reset),
    .id_valid(id_valid),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1),
    .id_use_rs2(id_use_rs2),
    .id_rd(id_rd),
    .id_regWrite(id_regWrite),
    .id_memRead(id_memRead),
    .flush(flush),
    .forwardA(fa_s), .forwardB(fb_s),
    .stall(st_s), .stall_count(cnt_s)
  );

  typedef struct {
    string      name;
    logic       stall;
    logic [1:0] fa;
    logic [1:0] fb;
    int         cnt;
  } exp_t;

  exp_t q[$];
  int   nvec = 0;
  int   nbad = 0;

  // One vector: drive ID inputs for a cycle and queue what the
  // outputs must show in that cycle (registered selects come
  // from the instruction presented one cycle earlier).
  task automatic v(
    input string      name,
    input logic       rst,
    input logic       vl,
    input logic [3:0] rs1, input logic u1,
    input logic [3:0] rs2, input logic u2,
    input logic [3:0] rd,
    input logic       rw, input logic mr,
    input logic       fl,
    input logic       e_st,
    input logic [1:0] e_fa, input logic [1:0] e_fb,
    input int         e_cnt
  );
    exp_t e;
    @(posedge clock);
    #1;
    reset = rst; id_valid = vl;
    id_rs1 = rs1; id_use_rs1 = u1;
    id_rs2 = rs2; id_use_rs2 = u2;
    id_rd = rd; id_regWrite = rw;
    id_memRead = mr; flush = fl;
    e.name = name; e.stall = e_st;
    e.fa = e_fa; e.fb = e_fb; e.cnt = e_cnt;
    q.push_back(e);
  endtask

  task automatic nop(input string name,
                     input logic [1:0] e_fa,
                     input logic [1:0] e_fb,
                     input int e_cnt);
    v(name, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,
      1'b0, e_fa, e_fb, e_cnt);
  endtask

  always @(negedge clock) begin
    if (q.size() > 0) begin
      exp_t e;
      int   ecs;
      e = q.pop_front();
      ecs = (e.cnt > 15) ? 15 : e.cnt;
      nvec++;
      if (st !== e.stall || fa !== e.fa || fb !== e.fb
          || cnt !== 16'(e.cnt)) begin
        nbad++;
        $display("FAIL %s: got st=%b fA=%b fB=%b cnt=%0d, want st=%b fA=%b fB=%b cnt=%0d",
                 e.name, st, fa, fb, cnt,
                 e.stall, e.fa, e.fb, e.cnt);
      end
      if (st_s !== e.stall || fa_s !== e.fa || fb_s !== e.fb
          || cnt_s !== 4'(ecs)) begin
        nbad++;
        $display("FAIL %s/narrow: got st=%b fA=%b fB=%b cnt=%0d, want st=%b fA=%b fB=%b cnt=%0d",
                 e.name, st_s, fa_s, fb_s, cnt_s,
                 e.stall, e.fa, e.fb, ecs);
      end
    end
  end

  initial begin
    repeat (2) @(posedge clock);
    // reset then idle
    nop("reset", 2'b00, 2'b00, 0);
    nop("idle",  2'b00, 2'b00, 0);
    // ADD r3 then SUB r3,r5
    v("add_r3", 0, 1, 1, 1, 2, 1, 3, 1, 0, 0,
      0, 2'b00, 2'b00, 0);
    v("sub_r3", 0, 1, 3, 1, 5, 1, 7, 1, 0, 0,
      0, 2'b00, 2'b00, 0);
    nop("ex_fwd", 2'b10, 2'b00, 0);
    // ADD r4, unrelated, reader r4/r4
    v("add_r4", 0, 1, 0, 0, 0, 0, 4, 1, 0, 0,
      0, 2'b00, 2'b00, 0);
    v("unrel", 0, 1, 1, 1, 2, 1, 8, 1, 0, 0,
      0, 2'b00, 2'b00, 0);
    v("rd_r4", 0, 1, 4, 1, 4, 1, 9, 1, 0, 0,
      0, 2'b00, 2'b00, 0);
    nop("mem_fwd", 2'b01, 2'b01, 0);
    // r2 in EX and MEM: newest wins
    v("p1_r2", 0, 1, 0, 0, 0, 0, 2, 1, 0, 0,
      0, 2'b00, 2'b00, 0);
    v("p2_r2", 0, 1, 0, 0, 0, 0, 2, 1, 0, 0,
      0, 2'b00, 2'b00, 0);
    v("rd_r2", 0, 1, 2, 1, 2, 1, 10, 1, 0, 0,
      0, 2'b00, 2'b00, 0);
    // load-use on r6
    v("ld_r6", 0, 1, 1, 1, 0, 0, 6, 1, 1, 0,
      0, 2'b10, 2'b10, 0);
    v("lu_stall", 0, 1, 6, 1, 3, 1, 11, 1, 0, 0,
      1, 2'b00, 2'b00, 0);
    v("lu_bubble", 0, 1, 6, 1, 3, 1, 11, 1, 0, 0,
      0, 2'b00, 2'b00, 1);
    nop("lu_fwd", 2'b01, 2'b00, 1);
    // load-use with flush in the same cycle
    v("ld_r6b", 0, 1, 1, 1, 0, 0, 6, 1, 1, 0,
      0, 2'b00, 2'b00, 1);
    v("lu_flush", 0, 1, 6, 1, 0, 0, 11, 1, 0, 1,
      0, 2'b00, 2'b00, 1);
    nop("post_flush", 2'b00, 2'b00, 1);
    // r0 producer never forwards or stalls
    v("ld_r0", 0, 1, 0, 0, 0, 0, 0, 1, 1, 0,
      0, 2'b00, 2'b00, 1);
    v("rd_r0", 0, 1, 0, 1, 0, 1, 12, 1, 0, 0,
      0, 2'b00, 2'b00, 1);
    nop("r0_fwd", 2'b00, 2'b00, 1);
    // invalid ID instruction never stalls
    v("ld_r6c", 0, 1, 0, 0, 0, 0, 6, 1, 1, 0,
      0, 2'b00, 2'b00, 1);
    v("inv_rd6", 0, 0, 6, 1, 6, 1, 13, 1, 0, 0,
      0, 2'b00, 2'b00, 1);
    nop("inv_fwd", 2'b00, 2'b00, 1);
    // repeated hazards: narrow counter saturates at 15
    for (int i = 0; i < 20; i++) begin
      v("sat_ld", 0, 1, 0, 0, 0, 0, 6, 1, 1, 0,
        0, 2'b00, 2'b00, 1 + i);
      v("sat_use", 0, 1, 6, 1, 0, 0, 0, 0, 0, 0,
        1, 2'b00, 2'b00, 1 + i);
    end
    nop("sat_end", 2'b00, 2'b00, 21);
    nop("sat_hold", 2'b00, 2'b00, 21);
    // reset during a stall cycle
    v("rst_ld", 0, 1, 0, 0, 0, 0, 6, 1, 1, 0,
      0, 2'b00, 2'b00, 21);
    v("rst_stall", 1, 1, 6, 1, 0, 0, 14, 1, 0, 0,
      1, 2'b00, 2'b00, 21);
    v("rst_after", 0, 1, 6, 1, 0, 0, 14, 1, 0, 0,
      0, 2'b00, 2'b00, 0);
    nop("rst_fwd", 2'b00, 2'b00, 0);
    for (int k = 0; k < 10 && q.size() > 0; k++)
      @(posedge clock);
    if (q.size() > 0) begin
      nbad++;
      $display("FAIL drain: %0d left, want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nbad);
    $finish;
  end

endmodule
